// File: rtl/tlc_pkg.sv
// Shared constants, arbiter state type and small index helpers for the
// traffic light controller sensor front end.
package tlc_pkg;

   localparam int NUM_APPROACH       = 4;
   localparam int LOOPS_PER_APPROACH = 3;

   localparam logic [1:0] APP_A = 2'd0;
   localparam logic [1:0] APP_B = 2'd1;
   localparam logic [1:0] APP_C = 2'd2;
   localparam logic [1:0] APP_D = 2'd3;

   localparam int LOOP_NEAR = 0;
   localparam int LOOP_MID  = 1;
   localparam int LOOP_FAR  = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      HOLD  = 2'd2
   } siren_state_t;

   // Lowest-numbered active request; approach a wins ties.
   function automatic logic [1:0] lowest_index(input logic [3:0] req);
      logic [1:0] idx;
      if (req[APP_A]) begin
         idx = APP_A;
      end else if (req[APP_B]) begin
         idx = APP_B;
      end else if (req[APP_C]) begin
         idx = APP_C;
      end else begin
         idx = APP_D;
      end
      return idx;
   endfunction

   // One-hot grant vector for an approach index.
   function automatic logic [3:0] one_hot(input logic [1:0] idx);
      logic [3:0] vec;
      case (idx)
         APP_A:   vec = 4'b0001;
         APP_B:   vec = 4'b0010;
         APP_C:   vec = 4'b0100;
         APP_D:   vec = 4'b1000;
         default: vec = 4'b0000;
      endcase
      return vec;
   endfunction

endpackage

// File: rtl/tlc_debounce.sv
// Single-bit debouncer: the stable value flips only after the raw input has
// disagreed with it for DEBOUNCE consecutive samples.
module tlc_debounce #(
   parameter int DEBOUNCE = 16
) (
   input  logic clock,
   input  logic clear,
   input  logic raw,
   output logic stable
);

   localparam logic [7:0] LAST_COUNT = 8'(DEBOUNCE - 1);

   logic [7:0] count_r;
   logic       stable_r;

   // Count consecutive disagreeing samples; flip on the last one.
   always_ff @(posedge clock) begin
      if (clear) begin
         stable_r <= 1'b0;
         count_r  <= 8'd0;
      end else if (raw == stable_r) begin
         count_r  <= 8'd0;
      end else if (count_r >= LAST_COUNT) begin
         stable_r <= ~stable_r;
         count_r  <= 8'd0;
      end else begin
         count_r  <= count_r + 8'd1;
      end
   end

   assign stable = stable_r;

endmodule

// File: rtl/tlc_sensor_conditioner.sv
// Sensor front end for the traffic light controller: debounces loops, sirens
// and red-light sensors, builds thermometer density levels and arbitrates a
// single emergency grant with a release hold.
module tlc_sensor_conditioner
   import tlc_pkg::*;
#(
   parameter int DEBOUNCE   = 16,
   parameter int SIREN_HOLD = 64
) (
   input  logic        clock,
   input  logic        clear,
   input  logic [11:0] raw_loop,
   input  logic [3:0]  raw_siren,
   input  logic [3:0]  raw_rc,
   output logic [11:0] density,
   output logic [3:0]  ss,
   output logic [3:0]  rc
);

   localparam int         NUM_LOOPS = NUM_APPROACH * LOOPS_PER_APPROACH;
   localparam logic [9:0] HOLD_LOAD = 10'(SIREN_HOLD - 1);

   logic [11:0]  loop_stable_s;
   logic [3:0]   siren_stable_s;
   logic [3:0]   rc_stable_s;
   siren_state_t state_r;
   logic [1:0]   own_r;
   logic [9:0]   hold_cnt_r;
   logic [3:0]   ss_r;

   for (genvar i = 0; i < NUM_LOOPS; i++) begin : g_loop_db
      tlc_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
         .clock  (clock),
         .clear  (clear),
         .raw    (raw_loop[i]),
         .stable (loop_stable_s[i])
      );
   end

   for (genvar i = 0; i < NUM_APPROACH; i++) begin : g_app_db
      tlc_debounce #(.DEBOUNCE(DEBOUNCE)) u_siren_db (
         .clock  (clock),
         .clear  (clear),
         .raw    (raw_siren[i]),
         .stable (siren_stable_s[i])
      );
      tlc_debounce #(.DEBOUNCE(DEBOUNCE)) u_rc_db (
         .clock  (clock),
         .clear  (clear),
         .raw    (raw_rc[i]),
         .stable (rc_stable_s[i])
      );
   end

   // A level only counts when every nearer loop is also occupied, so gaps
   // are masked and each approach always reads as thermometer code.
   for (genvar a = 0; a < NUM_APPROACH; a++) begin : g_density
      localparam int B = a * LOOPS_PER_APPROACH;
      assign density[B + LOOP_NEAR] = loop_stable_s[B + LOOP_NEAR];
      assign density[B + LOOP_MID]  = loop_stable_s[B + LOOP_NEAR]
                                    & loop_stable_s[B + LOOP_MID];
      assign density[B + LOOP_FAR]  = loop_stable_s[B + LOOP_NEAR]
                                    & loop_stable_s[B + LOOP_MID]
                                    & loop_stable_s[B + LOOP_FAR];
   end

   assign rc = rc_stable_s;

   // Siren arbiter: one owner at a time, held for SIREN_HOLD cycles after its
   // siren drops; new owners are only picked from IDLE.
   always_ff @(posedge clock) begin
      if (clear) begin
         state_r    <= IDLE;
         own_r      <= APP_A;
         hold_cnt_r <= 10'd0;
         ss_r       <= 4'b0000;
      end else begin
         case (state_r)
            IDLE: begin
               if (|siren_stable_s) begin
                  own_r   <= lowest_index(siren_stable_s);
                  ss_r    <= one_hot(lowest_index(siren_stable_s));
                  state_r <= GRANT;
               end else begin
                  ss_r    <= 4'b0000;
               end
            end
            GRANT: begin
               ss_r <= one_hot(own_r);
               if (!siren_stable_s[own_r]) begin
                  hold_cnt_r <= HOLD_LOAD;
                  state_r    <= HOLD;
               end else begin
                  state_r    <= GRANT;
               end
            end
            HOLD: begin
               if (siren_stable_s[own_r]) begin
                  ss_r    <= one_hot(own_r);
                  state_r <= GRANT;
               end else if (hold_cnt_r == 10'd0) begin
                  ss_r    <= 4'b0000;
                  state_r <= IDLE;
               end else begin
                  ss_r       <= one_hot(own_r);
                  hold_cnt_r <= hold_cnt_r - 10'd1;
               end
            end
            default: begin
               ss_r    <= 4'b0000;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign ss = ss_r;

endmodule

// File: tb/tb_tlc_sensor_conditioner.sv
// Directed, table-driven bench for tlc_sensor_conditioner (DEBOUNCE=16,
// SIREN_HOLD=64). Inputs are driven 1 time unit after a rising edge and
// outputs sampled at the same point.
module tb_tlc_sensor_conditioner;

   logic        clock;
   logic        clear;
   logic [11:0] raw_loop;
   logic [3:0]  raw_siren;
   logic [3:0]  raw_rc;
   logic [11:0] density;
   logic [3:0]  ss;
   logic [3:0]  rc;

   int vectors;
   int miscompares;

   typedef struct {
      logic [11:0] raw_loop;
      logic [3:0]  raw_rc;
      int          wait_cycles;
      logic [11:0] exp_density;
      logic [3:0]  exp_rc;
   } vec_t;

   vec_t tbl [9];

   tlc_sensor_conditioner #(.DEBOUNCE(16), .SIREN_HOLD(64)) dut (
      .clock     (clock),
      .clear     (clear),
      .raw_loop  (raw_loop),
      .raw_siren (raw_siren),
      .raw_rc    (raw_rc),
      .density   (density),
      .ss        (ss),
      .rc        (rc)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;

      tbl[0] = '{12'h020, 4'h0, 16, 12'h000, 4'h0};
      tbl[1] = '{12'h038, 4'h0, 16, 12'h038, 4'h0};
      tbl[2] = '{12'h018, 4'h0, 16, 12'h018, 4'h0};
      tbl[3] = '{12'hECE, 4'hA, 16, 12'hEC8, 4'hA};
      tbl[4] = '{12'hB95, 4'h5, 16, 12'h201, 4'h5};
      tbl[5] = '{12'h000, 4'h0, 16, 12'h000, 4'h0};
      tbl[6] = '{12'hFFF, 4'hF, 15, 12'h000, 4'h0};
      tbl[7] = '{12'hFFF, 4'hF,  1, 12'hFFF, 4'hF};
      tbl[8] = '{12'h000, 4'h0, 16, 12'h000, 4'h0};

      // Reset, including busy inputs while clear is held.
      clear     = 1'b1;
      raw_loop  = 12'hFFF;
      raw_siren = 4'hF;
      raw_rc    = 4'hF;
      tick(1);
      check("reset_density", density, 12'h000);
      check("reset_ss", {8'h00, ss}, 12'h000);
      check("reset_rc", {8'h00, rc}, 12'h000);
      tick(20);
      check("held_density", density, 12'h000);
      check("held_ss", {8'h00, ss}, 12'h000);
      check("held_rc", {8'h00, rc}, 12'h000);
      raw_loop  = 12'h000;
      raw_siren = 4'h0;
      raw_rc    = 4'h0;
      clear     = 1'b0;
      tick(2);

      // Glitch of 15 samples is rejected.
      raw_loop = 12'h001;
      for (int k = 0; k < 15; k++) begin
         tick(1);
         check("glitch_density", density, 12'h000);
      end
      raw_loop = 12'h000;
      tick(1);
      check("glitch_end", density, 12'h000);

      // Held for 16 samples flips at the 16th edge.
      raw_loop = 12'h001;
      tick(15);
      check("debounce_edge15", density, 12'h000);
      tick(1);
      check("debounce_edge16", density, 12'h001);
      raw_loop = 12'h000;
      tick(16);
      check("debounce_release", density, 12'h000);

      // Steady-state density and rc vectors.
      for (int v = 0; v < 9; v++) begin
         raw_loop = tbl[v].raw_loop;
         raw_rc   = tbl[v].raw_rc;
         tick(tbl[v].wait_cycles);
         check($sformatf("tbl%0d_density", v), density, tbl[v].exp_density);
         check($sformatf("tbl%0d_rc", v), {8'h00, rc}, {8'h00, tbl[v].exp_rc});
         check($sformatf("tbl%0d_ss", v), {8'h00, ss}, 12'h000);
      end

      // Siren priority: approaches b and d together, b wins.
      raw_siren = 4'b1010;
      tick(16);
      check("prio_before", {8'h00, ss}, 12'h000);
      tick(1);
      check("prio_grant", {8'h00, ss}, 12'h002);
      tick(30);
      check("prio_keep", {8'h00, ss}, 12'h002);

      // Owner b drops while d stays high: hold, one idle cycle, grant d.
      raw_siren = 4'b1000;
      tick(80);
      check("hold_last", {8'h00, ss}, 12'h002);
      tick(1);
      check("hold_release", {8'h00, ss}, 12'h000);
      tick(1);
      check("regrant_d", {8'h00, ss}, 12'h008);

      // Owner d drops, then returns while still in HOLD.
      raw_siren = 4'b0000;
      tick(40);
      check("hold2_mid", {8'h00, ss}, 12'h008);
      raw_siren = 4'b1000;
      tick(45);
      check("reassert_keep", {8'h00, ss}, 12'h008);
      raw_siren = 4'b0000;
      tick(80);
      check("rehold_last", {8'h00, ss}, 12'h008);
      tick(1);
      check("rehold_release", {8'h00, ss}, 12'h000);

      // Reset in the middle of a hold.
      raw_loop  = 12'h007;
      raw_rc    = 4'b0001;
      raw_siren = 4'b0100;
      tick(16);
      check("pre_rc", {8'h00, rc}, 12'h001);
      check("pre_density", density, 12'h007);
      tick(1);
      check("pre_ss", {8'h00, ss}, 12'h004);
      raw_siren = 4'b0000;
      tick(20);
      check("pre_hold_ss", {8'h00, ss}, 12'h004);
      clear = 1'b1;
      tick(1);
      check("mid_reset_density", density, 12'h000);
      check("mid_reset_ss", {8'h00, ss}, 12'h000);
      check("mid_reset_rc", {8'h00, rc}, 12'h000);
      clear = 1'b0;
      tick(15);
      check("post_rc_edge15", {8'h00, rc}, 12'h000);
      tick(1);
      check("post_rc_edge16", {8'h00, rc}, 12'h001);
      check("post_density", density, 12'h007);
      check("post_ss", {8'h00, ss}, 12'h000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/tlc_sensor_conditioner.md
# tlc_sensor_conditioner

Front-end stage that conditions raw roadside sensor signals before they reach the traffic light controller FSM. It debounces the 12 loop detectors (3 per approach), the 4 emergency-siren detectors and the 4 red-light-violation sensors. It emits thermometer-coded queue-density levels, a one-hot emergency grant with release hold, and clean violation flags. Its outputs drive the controller's `a1..d3`, `ss1..ss4` and `rc1..rc4` inputs directly.

## Interface
Parameters:
- `DEBOUNCE`, 16, number of consecutive cycles a raw input must differ from its debounced value before that value flips (legal range 2..255).
- `SIREN_HOLD`, 64, number of cycles an emergency grant persists after its siren drops (legal range 1..1023).

Ports:
- `clock`  in  1  single system clock; all state updates on its rising edge.
- `clear`  in  1  reset; synchronous, active-high.
- `raw_loop`  in  12  raw loop detectors; bit 3*i+k belongs to approach i (0=a, 1=b, 2=c, 3=d) and loop k (0=near, 1=mid, 2=far).
- `raw_siren`  in  4  raw siren detector, one bit per approach.
- `raw_rc`  in  4  raw red-light violation sensor, one bit per approach.
- `density`  out  12  thermometer-coded level; bit 3*i+k maps to controller input `<approach i><k+1>`, e.g. bit 4 maps to `b2`.
- `ss`  out  4  one-hot emergency grant, maps to `ss1..ss4`.
- `rc`  out  4  debounced violation flags, maps to `rc1..rc4`.

## Operation
- **Debounce, per bit (20 instances):**
  - State is a `stable` register plus a counter.
  - In any cycle where raw equals `stable`, the counter clears.
  - In any cycle where raw differs from `stable`, the counter increments.
  - When the counter reaches `DEBOUNCE-1` and raw still differs, `stable` flips and the counter clears.
- **Density:**
  - level1 = `near`.
  - level2 = `near & mid`.
  - level3 = `near & mid & far`.
  - Gaps are masked, so a far-only detection yields 000. The output is therefore always thermometer code (000/001/011/111 per approach).
- **rc:** equals the debounced `raw_rc`.
- **Siren arbiter FSM**, with states IDLE, GRANT, HOLD and an owner index `own[1:0]`:
  - *IDLE:* `ss`=0. If any debounced siren is high, take `own` = the lowest such index and go to GRANT. Otherwise stay in IDLE.
  - *GRANT:* `ss` = one-hot(`own`). If siren[`own`] is still high, stay. If it has dropped, load `hold_cnt` = `SIREN_HOLD-1` and go to HOLD.
  - *HOLD:* `ss` = one-hot(`own`). If siren[`own`] reasserts, go to GRANT. Else if `hold_cnt`==0, go to IDLE. Else decrement `hold_cnt`.
  - Sirens on non-owner approaches are ignored until the arbiter returns to IDLE.
  - There is no direct HOLD→GRANT handover to a different approach; a new owner is chosen only from IDLE.
- **Invariant:** `ss` never has more than one bit set. The controller's multi-`ss` behaviour is never exercised.

## Timing
- **Reset:** while `clear` is sampled high, all `stable` bits = 0, all counters = 0, FSM = IDLE, `own` = 0. Consequently `density` = 0, `ss` = 0 and `rc` = 0 from the first edge after reset, and they stay 0 while `clear` is held.
- **Reset mid-operation:** applies the same way. A pending debounce or hold count is discarded with no partial output.
- **Debounce latency:** a raw change held steadily from edge n flips `stable` at edge n+`DEBOUNCE-1`.
  - `density` and `rc` are pure functions of the `stable` registers, so they are valid in that same cycle with no extra register stage.
  - A glitch shorter than `DEBOUNCE` cycles produces no output change.
- **`ss` assertion:** from IDLE, `ss` asserts one edge after the debounced siren rises. Total latency from a raw siren rise is `DEBOUNCE` edges.
- **`ss` release:**
  - `ss` stays high during HOLD.
  - It deasserts exactly `SIREN_HOLD` edges after the edge at which the FSM enters HOLD, including the IDLE transition edge.
  - Total from the debounced drop is `SIREN_HOLD`+1 edges.
- **Simultaneous siren rise on several approaches:** the lowest index wins.
- **Owner drop and another siren high in the same cycle:** the FSM goes to HOLD for the owner. The other approach is granted only after return to IDLE, one edge after HOLD expires.

## Structure
- Package `tlc_pkg` holds:
  - `NUM_APPROACH`=4 and `LOOPS_PER_APPROACH`=3;
  - approach index constants `APP_A..APP_D` and loop index constants `LOOP_NEAR/MID/FAR`;
  - the arbiter state typedef `siren_state_t` {IDLE, GRANT, HOLD}.
- Sub-module `tlc_debounce` (1-bit, parameter `DEBOUNCE`; ports `clock`, `clear`, `raw`, `stable`) is instantiated 20 times.
- Density masking and the arbiter live in the top level.

## Test plan
- **Debounce glitch rejection:** with `DEBOUNCE`=16, pulse `raw_loop[0]` high for 15 cycles, then low → `density`=0 throughout. Hold it for 16 cycles → `density[0]`=1 at the 16th edge.
- **Thermometer masking:** `raw_loop[5:3]`=3'b100 held → `density[5:3]`=000. Then 3'b111 → 111. Then 3'b011 → 011.
- **Siren priority:** `raw_siren`=4'b1010 rising together → `ss`=4'b0010 one edge after debounce. Stays 0010 while `raw_siren[1]` is high, even if bit 3 is high.
- **Hold and re-grant:** with `SIREN_HOLD`=64, drop `raw_siren[1]` while bit 3 is still high → `ss`=0010 for 64 more edges after the debounced drop. Then `ss`=0 for one cycle, then `ss`=1000.
- **Reassert in HOLD:** the owner's siren returns (debounced) at hold count 10 → `ss` is unchanged and the FSM re-enters GRANT. A later drop restarts the full 64-cycle hold.
- **Reset mid-operation:** `clear` asserted during HOLD with `raw_rc`=4'b0001 stable → `density`, `ss`, `rc` = 0 on the next edge. After `clear` deasserts, `rc[0]` returns after `DEBOUNCE` edges.
